cheshire_soc_fixture_ctrl: RTL and testbench



---
 rtl/cheshire_soc_fixture_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_cheshire_soc_fixture_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cheshire_soc_fixture_ctrl.sv
// Bring-up sequencer for the Cheshire SoC harness: straps, SoC reset, preload, debug-path writes, EOC polling.
// Optional EOC timeout is enabled by defining CHESHIRE_FIXTURE_EOC_TIMEOUT_EN.
module cheshire_soc_fixture_ctrl #(
  parameter logic [63:0] SpmBase       = 64'h0000_0000_1000_0000,
  parameter logic [63:0] EocAddr       = 64'h0000_0000_0200_4004,
  parameter logic [63:0] DmActAddr     = 64'h0000_0000_0000_0040,
  parameter logic [63:0] EntryAddr     = 64'h0000_0000_0000_0100,
  parameter logic [63:0] ResumeAddr    = 64'h0000_0000_0000_0108,
  parameter int unsigned ResetCycles   = 16,
  parameter int unsigned PollInterval  = 32,
  parameter int unsigned TimeoutCycles = 2**20
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  boot_mode_i,
  input  logic        test_mode_i,
  input  logic        entry_valid_i,
  input  logic [63:0] entry_i,
  output logic [1:0]  boot_mode_o,
  output logic        test_mode_o,
  output logic        soc_rst_no,
  output logic        preload_req_o,
  input  logic        preload_done_i,
  output logic        req_o,
  output logic        we_o,
  output logic [63:0] addr_o,
  output logic [63:0] wdata_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [63:0] rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        success_o,
  output logic        timeout_o,
  output logic [30:0] exit_code_o,
  output logic [3:0]  dbg_state_o
);

  // Bus handshake: req_o/we_o/addr_o/wdata_o are held until gnt_i is sampled high;
  // the transaction then stays outstanding (pend) until rvalid_i. One at a time.
  typedef enum logic [3:0] {
    S_IDLE, S_RESET, S_PRELOAD, S_DM_INIT, S_WR_ENTRY,
    S_WR_RESUME, S_POLL_WAIT, S_POLL_RD, S_DONE, S_TIMEOUT
  } state_e;

  state_e      state;
  logic [63:0] entry_q;
  logic [31:0] cnt;
  logic        pend;
  logic        txn_done;
  logic        tmo_hit;

  assign txn_done    = pend & rvalid_i;
  assign dbg_state_o = 4'(state);

`ifdef CHESHIRE_FIXTURE_EOC_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_run;
  assign tmo_run = (state == S_POLL_WAIT) || (state == S_POLL_RD);
  assign tmo_hit = tmo_run && (tmo_cnt == 32'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt   <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (state == S_WR_RESUME) tmo_cnt <= '0;
      else if (tmo_run)         tmo_cnt <= tmo_cnt + 32'd1;
      if (tmo_hit) timeout_o <= 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^rdata_i[63:32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      entry_q       <= '0;
      cnt           <= '0;
      pend          <= 1'b0;
      boot_mode_o   <= '0;
      test_mode_o   <= 1'b0;
      soc_rst_no    <= 1'b0;
      preload_req_o <= 1'b0;
      req_o         <= 1'b0;
      we_o          <= 1'b0;
      addr_o        <= '0;
      wdata_o       <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      success_o     <= 1'b0;
      exit_code_o   <= '0;
    end else begin
      if (req_o && gnt_i) begin
        req_o <= 1'b0;
        we_o  <= 1'b0;
        pend  <= 1'b1;
      end else if (txn_done) begin
        pend <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start_i) begin
            state       <= S_RESET;
            boot_mode_o <= boot_mode_i;
            test_mode_o <= test_mode_i;
            entry_q     <= entry_valid_i ? entry_i : SpmBase;
            busy_o      <= 1'b1;
            cnt         <= '0;
          end
        end
        S_RESET: begin
          if (cnt == 32'(ResetCycles - 1)) begin
            soc_rst_no    <= 1'b1;
            preload_req_o <= 1'b1;
            state         <= S_PRELOAD;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_PRELOAD: begin
          if (preload_done_i) begin
            preload_req_o <= 1'b0;
            state         <= S_DM_INIT;
            req_o         <= 1'b1;
            we_o          <= 1'b1;
            addr_o        <= DmActAddr;
            wdata_o       <= 64'd1;
          end
        end
        S_DM_INIT: begin
          if (txn_done) begin
            state   <= S_WR_ENTRY;
            req_o   <= 1'b1;
            we_o    <= 1'b1;
            addr_o  <= EntryAddr;
            wdata_o <= entry_q;
          end
        end
        S_WR_ENTRY: begin
          if (txn_done) begin
            state   <= S_WR_RESUME;
            req_o   <= 1'b1;
            we_o    <= 1'b1;
            addr_o  <= ResumeAddr;
            wdata_o <= 64'd1;
          end
        end
        S_WR_RESUME: begin
          if (txn_done) begin
            state <= S_POLL_WAIT;
            cnt   <= '0;
          end
        end
        S_POLL_WAIT: begin
          if (tmo_hit) begin
            state  <= S_TIMEOUT;
            busy_o <= 1'b0;
          end else if (cnt == 32'(PollInterval - 1)) begin
            state   <= S_POLL_RD;
            req_o   <= 1'b1;
            we_o    <= 1'b0;
            addr_o  <= EocAddr;
            wdata_o <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_POLL_RD: begin
          if (tmo_hit) begin
            // any read still in flight finishes through the handshake above; its data is dropped
            state  <= S_TIMEOUT;
            busy_o <= 1'b0;
          end else if (txn_done) begin
            if (rdata_i[0]) begin
              state       <= S_DONE;
              done_o      <= 1'b1;
              exit_code_o <= rdata_i[31:1];
              success_o   <= ~|rdata_i[31:1];
              busy_o      <= 1'b0;
            end else begin
              state <= S_POLL_WAIT;
              cnt   <= '0;
            end
          end
        end
        S_DONE:    ;
        S_TIMEOUT: begin
          done_o    <= 1'b0;
          success_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cheshire_soc_fixture_ctrl.sv
// Bench for cheshire_soc_fixture_ctrl: directed vector table, random sequences, reset-abort and timeout cases.
module tb_cheshire_soc_fixture_ctrl;

  localparam logic [63:0] SPM    = 64'h0000_0000_1000_0000;
  localparam logic [63:0] EOC    = 64'h0000_0000_0200_4004;
  localparam logic [63:0] DMACT  = 64'h0000_0000_0000_0040;
  localparam logic [63:0] ENTRYA = 64'h0000_0000_0000_0100;
  localparam logic [63:0] RESUME = 64'h0000_0000_0000_0108;
  localparam int RST_CYC = 16;
  localparam int POLL    = 32;
  localparam int TMO     = 3000;

  logic        clk_i, rst_ni, start_i, test_mode_i, entry_valid_i;
  logic [1:0]  boot_mode_i, boot_mode_o;
  logic [63:0] entry_i, addr_o, wdata_o, rdata_i;
  logic        test_mode_o, soc_rst_no, preload_req_o, preload_done_i;
  logic        req_o, we_o, gnt_i, rvalid_i;
  logic        busy_o, done_o, success_o, timeout_o;
  logic [30:0] exit_code_o;
  logic [3:0]  dbg_state;

  cheshire_soc_fixture_ctrl #(.TimeoutCycles(TMO)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .boot_mode_i(boot_mode_i), .test_mode_i(test_mode_i),
    .entry_valid_i(entry_valid_i), .entry_i(entry_i),
    .boot_mode_o(boot_mode_o), .test_mode_o(test_mode_o), .soc_rst_no(soc_rst_no),
    .preload_req_o(preload_req_o), .preload_done_i(preload_done_i),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .busy_o(busy_o), .done_o(done_o), .success_o(success_o), .timeout_o(timeout_o),
    .exit_code_o(exit_code_o), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: expected bus transactions {we, addr, wdata}, and EOC read responses
  logic [128:0] exp_q[$];
  logic [63:0]  rsp_q[$];
  bit   rand_mode, inf_poll;
  int   gnt_dly, rv_dly;
  bit   pending, in_req, cur_read, chk_done;
  int   gcnt, rcnt, last_rsp_cyc, reads_seen;
  logic [128:0] held, cur, e;
  logic [30:0]  chk_exit;

  // bus slave
  initial begin
    gnt_i = 0; rvalid_i = 0; rdata_i = 0;
    pending = 0; in_req = 0; chk_done = 0; last_rsp_cyc = 0; reads_seen = 0;
    forever begin
      @(negedge clk_i);
      gnt_i = 0; rvalid_i = 0; rdata_i = {$urandom, $urandom};
      if (chk_done) begin
        check("done_next_cycle", done_o, 1);
        check("exit_next_cycle", exit_code_o, chk_exit);
        chk_done = 0;
      end
      if (!rst_ni) begin
        pending = 0; in_req = 0;
        continue;
      end
      cur = {we_o, addr_o, wdata_o};
      if (pending) begin
        check("one_outstanding", req_o, 0);
        if (rcnt == 0) begin
          rvalid_i = 1; pending = 0; last_rsp_cyc = cyc;
          if (cur_read) begin
            rdata_i = (rsp_q.size() > 0) ? rsp_q.pop_front() : 64'h0;
            if (rdata_i[0] && !inf_poll) begin
              chk_done = 1; chk_exit = rdata_i[31:1];
            end
          end
        end else rcnt--;
      end else if (req_o) begin
        if (!in_req) begin
          in_req = 1; held = cur;
          gcnt = rand_mode ? $urandom_range(0, 4) : gnt_dly;
          if (!we_o) begin
            reads_seen++;
            check("poll_gap", (cyc - last_rsp_cyc) >= POLL, 1);
          end
        end else check("req_stable", cur, held);
        if (gcnt == 0) begin
          gnt_i = 1; in_req = 0; pending = 1; cur_read = !we_o;
          rcnt = (rand_mode ? $urandom_range(1, 4) : rv_dly) - 1;
          if (exp_q.size() == 0) begin
            if (!(inf_poll && !we_o && addr_o == EOC)) begin
              n_tests++; n_fail++;
              $display("FAIL unexpected_txn: got %0h expected none", cur);
            end
          end else begin
            e = exp_q.pop_front();
            check("txn_we_addr", cur[128:64], e[128:64]);
            if (e[128]) check("txn_wdata", cur[63:0], e[63:0]);
          end
        end else begin
          gcnt--;
          if (rand_mode && $urandom_range(0, 7) == 0) begin rvalid_i = 1; rdata_i = 64'h1; end
        end
      end else if (rand_mode && $urandom_range(0, 7) == 0) begin
        rvalid_i = 1; rdata_i = 64'h1;
      end
    end
  end

  typedef struct {
    logic        ev;
    logic [63:0] entry;
    logic [1:0]  boot;
    logic        tm;
    int          npolls;
    logic [63:0] eoc;
    int          gdly;
    int          rdly;
    logic [63:0] exp_entry;
    logic [30:0] exp_exit;
    logic        exp_succ;
  } vec_t;

  vec_t vecs[4];

  task automatic check_reset_vals(input string tag);
    check({tag, "_soc_rst_n"}, soc_rst_no, 0);
    check({tag, "_boot"}, boot_mode_o, 0);
    check({tag, "_test"}, test_mode_o, 0);
    check({tag, "_preload"}, preload_req_o, 0);
    check({tag, "_req_we"}, {req_o, we_o}, 0);
    check({tag, "_addr"}, addr_o, 0);
    check({tag, "_wdata"}, wdata_o, 0);
    check({tag, "_flags"}, {busy_o, done_o, success_o, timeout_o}, 0);
    check({tag, "_exit"}, exit_code_o, 0);
  endtask

  task automatic apply_reset();
    rst_ni = 0; start_i = 0; preload_done_i = 0;
    repeat (3) @(negedge clk_i);
    check_reset_vals("rst");
    rst_ni = 1;
    @(negedge clk_i);
  endtask

  task automatic push_writes(input logic [63:0] ent);
    exp_q.push_back({1'b1, DMACT, 64'd1});
    exp_q.push_back({1'b1, ENTRYA, ent});
    exp_q.push_back({1'b1, RESUME, 64'd1});
  endtask

  task automatic start_seq(input logic ev, input logic [63:0] ent, input logic [1:0] bm, input logic tm);
    int n;
    boot_mode_i = bm; test_mode_i = tm; entry_valid_i = ev; entry_i = ent; start_i = 1;
    @(negedge clk_i);
    start_i = 0; boot_mode_i = ~bm; test_mode_i = ~tm; entry_valid_i = ~ev; entry_i = ~ent;
    n = 0;
    while (soc_rst_no == 0 && n < 100) begin n++; @(negedge clk_i); end
    check("rst_hold_cycles", n, RST_CYC);
    check("busy_running", busy_o, 1);
    check("preload_req", preload_req_o, 1);
    repeat ($urandom_range(0, 4)) @(negedge clk_i);
    check("preload_req_held", preload_req_o, 1);
    preload_done_i = 1;
    @(negedge clk_i);
    preload_done_i = 0;
    check("preload_clr", preload_req_o, 0);
  endtask

  task automatic run_case(input vec_t v, input bit rnd);
    int k;
    exp_q.delete(); rsp_q.delete();
    inf_poll = 0; rand_mode = rnd; gnt_dly = v.gdly; rv_dly = v.rdly;
    apply_reset();
    push_writes(v.exp_entry);
    for (int i = 0; i < v.npolls; i++) begin
      rsp_q.push_back(rnd ? ({$urandom, $urandom} & ~64'h1) : 64'h0);
      exp_q.push_back({1'b0, EOC, 64'h0});
    end
    rsp_q.push_back(v.eoc);
    exp_q.push_back({1'b0, EOC, 64'h0});
    start_seq(v.ev, v.entry, v.boot, v.tm);
    k = 0;
    while (!done_o && k < 20000) begin
      start_i = (k == 40);
      k++;
      @(negedge clk_i);
    end
    start_i = 0;
    check("done_seen", done_o, 1);
    check("exit_code", exit_code_o, v.exp_exit);
    check("success", success_o, v.exp_succ);
    check("busy_cleared", busy_o, 0);
    check("timeout_clear", timeout_o, 0);
    check("straps", {boot_mode_o, test_mode_o}, {v.boot, v.tm});
    check("soc_out_of_reset", soc_rst_no, 1);
    check("txn_left", exp_q.size(), 0);
    repeat (8) @(negedge clk_i);
    check("done_held", {done_o, exit_code_o}, {1'b1, v.exp_exit});
  endtask

  task automatic reset_mid_poll();
    int k;
    exp_q.delete(); rsp_q.delete();
    inf_poll = 1; rand_mode = 1;
    apply_reset();
    push_writes(SPM);
    reads_seen = 0;
    start_seq(1'b0, 64'h0, 2'b11, 1'b1);
    k = 0;
    while (reads_seen < 2 && k < 2000) begin k++; @(negedge clk_i); end
    check("mid_poll_reached", reads_seen >= 2, 1);
    repeat ($urandom_range(0, 10)) @(negedge clk_i);
    #2 rst_ni = 0;
    #1 check_reset_vals("async");
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    exp_q.delete();
    repeat (3) @(negedge clk_i);
    check("idle_after_abort", {busy_o, req_o, soc_rst_no}, 0);
  endtask

`ifdef CHESHIRE_FIXTURE_EOC_TIMEOUT_EN
  task automatic timeout_case();
    int k;
    exp_q.delete(); rsp_q.delete();
    inf_poll = 1; rand_mode = 1;
    apply_reset();
    push_writes(SPM);
    start_seq(1'b0, 64'h0, 2'b01, 1'b0);
    k = 0;
    while (!timeout_o && k < TMO + 500) begin k++; @(negedge clk_i); end
    check("timeout_set", timeout_o, 1);
    check("timeout_no_done", {done_o, success_o, busy_o}, 0);
    repeat (10) @(negedge clk_i);
    check("timeout_held", timeout_o, 1);
  endtask
`endif

  initial begin
    vec_t rv;
    logic [63:0] w;
    rst_ni = 0; start_i = 0; boot_mode_i = 0; test_mode_i = 0;
    entry_valid_i = 0; entry_i = 0; preload_done_i = 0;
    rand_mode = 0; inf_poll = 0; gnt_dly = 0; rv_dly = 1;

    vecs[0] = '{ev:1'b0, entry:64'h0, boot:2'b00, tm:1'b0, npolls:0, eoc:64'h1, gdly:0, rdly:1,
                exp_entry:64'h1000_0000, exp_exit:31'd0, exp_succ:1'b1};
    vecs[1] = '{ev:1'b1, entry:64'h8000_0000, boot:2'b10, tm:1'b1, npolls:2, eoc:64'h1, gdly:1, rdly:1,
                exp_entry:64'h8000_0000, exp_exit:31'd0, exp_succ:1'b1};
    vecs[2] = '{ev:1'b0, entry:64'hdead_beef, boot:2'b01, tm:1'b0, npolls:1, eoc:64'h7, gdly:0, rdly:2,
                exp_entry:64'h1000_0000, exp_exit:31'd3, exp_succ:1'b0};
    vecs[3] = '{ev:1'b1, entry:64'h8000_1234_0000_0040, boot:2'b11, tm:1'b1, npolls:1, eoc:64'hffff_0000_0000_0055,
                gdly:5, rdly:3, exp_entry:64'h8000_1234_0000_0040, exp_exit:31'h2a, exp_succ:1'b0};

    for (int i = 0; i < 4; i++) run_case(vecs[i], 1'b0);

    reset_mid_poll();

    for (int i = 0; i < 8; i++) begin
      rv.ev     = 1'($urandom_range(0, 1));
      rv.entry  = {$urandom, $urandom};
      rv.boot   = 2'($urandom_range(0, 3));
      rv.tm     = 1'($urandom_range(0, 1));
      rv.npolls = $urandom_range(0, 3);
      w = {$urandom, $urandom} | 64'h1;
      if ($urandom_range(0, 3) == 0) w = {$urandom, 32'h1};
      rv.eoc    = w;
      rv.gdly   = 0;
      rv.rdly   = 1;
      rv.exp_entry = rv.ev ? rv.entry : SPM;
      rv.exp_exit  = w[31:1];
      rv.exp_succ  = (w[31:1] == 31'd0);
      run_case(rv, 1'b1);
    end

`ifdef CHESHIRE_FIXTURE_EOC_TIMEOUT_EN
    timeout_case();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
